sram_lsu: RTL

SRAM_LSU -- requirements
Module: sram_lsu

---
 rtl/sram_lsu.sv | 88 ++++++++
 1 files changed

// File: rtl/sram_lsu.sv
// sram_lsu: single-outstanding load/store unit for a 32-bit SRAM; sub-word stores
// are done as read-modify-write of the containing word.
module sram_lsu #(
    parameter logic [31:0] SRAM_LIMIT = 32'h0000FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] rdata_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] w_sram_o,
    output logic        w_sram_en_o,
    input  logic [31:0] r_sram_i
);
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, FLT} state_e;
    state_e      state_q, state_d;
    logic        we_q, sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, old_q, old_d, rdata_q, rdata_d;
    logic [32:0] last_byte;
    logic        bad;
    logic [4:0]  sh;
    logic [31:0] lane, ext, mask;
    // 33-bit sum so an access straddling 2^32 still counts as out of range
    assign last_byte = {1'b0, addr_i} + (size_i == 2'b10 ? 33'd3 : {32'd0, size_i[0]});
    assign bad = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) ||
                 (size_i == 2'b10 && addr_i[1:0] != 2'b00) || last_byte > {1'b0, SRAM_LIMIT};
    assign sh   = {addr_q[1:0], 3'b000};
    assign lane = r_sram_i >> sh;
    assign ext  = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : lane;
    assign mask = size_q == 2'b00 ? 32'h000000FF << sh :
                  size_q == 2'b01 ? 32'h0000FFFF << sh : 32'hFFFFFFFF;
    always_comb begin
        state_d = state_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_i) state_d = bad ? FLT : (!we_i || size_i != 2'b10) ? RD : WR;
            RD: begin
                state_d = we_q ? WR : DONE;
                old_d   = r_sram_i;
                rdata_d = we_q ? rdata_q : ext;
            end
            WR:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req_i) begin
                we_q    <= we_i;
                sgn_q   <= sgn_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE || state_q == FLT;
    assign fault_o     = state_q == FLT;
    assign rdata_o     = rdata_q;
    assign sram_addr_o = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : '0;
    assign w_sram_en_o = state_q == WR;
    // word stores use an all-ones mask, so the stale old_q never leaks through
    assign w_sram_o    = state_q == WR ? (old_q & ~mask) | ((wdata_q << sh) & mask) : '0;
endmodule
